// File: rtl/ngram_binder.sv
// Binds every N consecutive item slices into one n-gram (rotate-and-xor) and
// emits per-lane result bits with k_fin, followed by an s_fin at sample end.
module ngram_binder #(
  parameter int D  = 32,
  parameter int N  = 3,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [D-1:0]  s_data,
  input  logic          s_last,
  output logic [D-1:0]  result,
  output logic          k_fin,
  output logic          s_fin,
  output logic [CW-1:0] ngram_cnt
);

  // Handshake: a beat transfers on the rising edge where s_valid && s_ready;
  // s_ready is high only in ACC, and the source holds its beat otherwise.
  typedef enum logic [1:0] {ACC, DRAIN, FIN} state_t;

  localparam logic [7:0] LAST_IDX = 8'(N - 1);

  state_t        state_q, state_d;
  logic [D-1:0]  acc_q, acc_d;
  logic [D-1:0]  result_q, result_d;
  logic [7:0]    idx_q, idx_d;
  logic          k_fin_q, k_fin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic [D-1:0]  bound;

  assign s_ready   = (state_q == ACC) && !rst;
  assign accept    = s_valid && s_ready;
  assign bound     = {acc_q[D-2:0], acc_q[D-1]} ^ s_data;
  assign result    = result_q;
  assign k_fin     = k_fin_q;
  assign s_fin     = (state_q == FIN);
  assign ngram_cnt = cnt_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    k_fin_d  = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            result_d = bound;
            k_fin_d  = 1'b1;
            acc_d    = '0;
            idx_d    = '0;
            cnt_d    = cnt_q + CW'(1);
          end else begin
            acc_d = bound;
            idx_d = idx_q + 8'd1;
          end
          // A partial n-gram at sample end is dropped, never emitted.
          if (s_last) begin
            acc_d   = '0;
            idx_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: state_d = FIN;
      FIN: begin
        state_d = ACC;
        cnt_d   = '0;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACC;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      k_fin_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      k_fin_q  <= k_fin_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ngram_binder.sv
// Bench for ngram_binder: instance 0 uses D=8,N=3 and instance 1 uses D=8,N=1,
// both checked every cycle against a sample-level model plus literal checks.
module tb_ngram_binder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  s_valid = '0;
  logic [1:0]  s_last = '0;
  logic [7:0]  s_data [2];
  logic [1:0]  s_ready;
  logic [7:0]  result [2];
  logic [1:0]  k_fin;
  logic [1:0]  s_fin;
  logic [31:0] ngram_cnt [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ngram_binder #(.D(8), .N(3), .CW(32)) u_n3 (
    .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .s_last(s_last[0]), .result(result[0]),
    .k_fin(k_fin[0]), .s_fin(s_fin[0]), .ngram_cnt(ngram_cnt[0])
  );

  ngram_binder #(.D(8), .N(1), .CW(32)) u_n1 (
    .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .s_last(s_last[1]), .result(result[1]),
    .k_fin(k_fin[1]), .s_fin(s_fin[1]), .ngram_cnt(ngram_cnt[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- sample-level model ----------------
  int         ph [2];
  int         nitem [2];
  logic [7:0] items [2][256];
  logic [7:0] e_res [2];
  logic       e_k [2];
  logic [31:0] e_cnt [2];

  function automatic int nlen(input int id);
    return (id == 0) ? 3 : 1;
  endfunction

  // Direct form: item i is rotated left (n-1-i) times, then all are xored.
  function automatic logic [7:0] ngram_of(input int id);
    logic [7:0] r, x;
    r = '0;
    for (int i = 0; i < nlen(id); i++) begin
      x = items[id][i];
      for (int k = 0; k < nlen(id) - 1 - i; k++) x = {x[6:0], x[7]};
      r ^= x;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int id = 0; id < 2; id++) begin
        ph[id] = 0; nitem[id] = 0; e_res[id] = '0; e_k[id] = 1'b0; e_cnt[id] = '0;
      end
    end else begin
      cyc++;
      for (int id = 0; id < 2; id++) begin
        e_k[id] = 1'b0;
        case (ph[id])
          0: if (s_valid[id]) begin
            items[id][nitem[id]] = s_data[id];
            nitem[id]++;
            if (nitem[id] == nlen(id)) begin
              e_res[id] = ngram_of(id);
              e_k[id]   = 1'b1;
              e_cnt[id] = e_cnt[id] + 1;
              nitem[id] = 0;
            end
            if (s_last[id]) begin
              nitem[id] = 0;
              ph[id]    = 1;
            end
          end
          1: ph[id] = 2;
          default: begin
            ph[id]    = 0;
            e_cnt[id] = '0;
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  int         kcnt [2] = '{0, 0};
  int         fcnt [2] = '{0, 0};
  logic [7:0] last_res [2];
  logic [7:0] prev_res [2];
  int         k_cyc [2] = '{0, 0};
  int         prev_k_cyc [2] = '{0, 0};
  int         f_cyc [2] = '{0, 0};
  logic [31:0] fin_cnt [2];

  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      chk($sformatf("k_fin%0d", id), 32'(k_fin[id]), 32'(e_k[id]));
      chk($sformatf("s_fin%0d", id), 32'(s_fin[id]), 32'(ph[id] == 2 && !rst));
      chk($sformatf("s_ready%0d", id), 32'(s_ready[id]), 32'(ph[id] == 0 && !rst));
      chk($sformatf("result%0d", id), 32'(result[id]), 32'(e_res[id]));
      chk($sformatf("ngram_cnt%0d", id), ngram_cnt[id], e_cnt[id]);
      if (k_fin[id] && s_fin[id]) chk($sformatf("kfin_sfin_overlap%0d", id), 32'd1, 32'd0);
      if (k_fin[id]) begin
        kcnt[id]++;
        prev_res[id] = last_res[id];
        last_res[id] = result[id];
        prev_k_cyc[id] = k_cyc[id];
        k_cyc[id] = cyc;
      end
      if (s_fin[id]) begin
        fcnt[id]++;
        f_cyc[id] = cyc;
        fin_cnt[id] = ngram_cnt[id];
      end
    end
  end

  // ---------------- driver ----------------
  // Called and returning at posedge+2; valid stays asserted across calls.
  task automatic send(input int id, input logic [7:0] d, input logic last);
    logic rdy;
    bit   done;
    done = 0;
    s_valid[id] = 1'b1;
    s_data[id]  = d;
    s_last[id]  = last;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      rdy = s_ready[id];
      @(posedge clk);
      #2;
      if (rdy) done = 1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    s_valid[id] = 1'b0;
    s_last[id]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int kc, fc;

  initial begin
    s_data[0] = '0;
    s_data[1] = '0;
    #1;
    chk("rst_result", 32'(result[0]), 32'h0);
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    chk("rst_cnt", ngram_cnt[0], 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #2;

    // 01,01,01(last): result 07, one k_fin, s_fin one cycle later
    kc = kcnt[0]; fc = fcnt[0];
    send(0, 8'h01, 1'b0);
    send(0, 8'h01, 1'b0);
    send(0, 8'h01, 1'b1);
    idle(4);
    chk("t1_kfins", 32'(kcnt[0] - kc), 32'd1);
    chk("t1_result", 32'(last_res[0]), 32'h07);
    chk("t1_sfins", 32'(fcnt[0] - fc), 32'd1);
    chk("t1_fin_gap", 32'(f_cyc[0] - k_cyc[0]), 32'd1);
    chk("t1_cnt_in_fin", fin_cnt[0], 32'd1);

    // 81,00,00(last) -> 06, then next sample held during DRAIN/FIN -> 07
    kc = kcnt[0];
    send(0, 8'h81, 1'b0);
    send(0, 8'h00, 1'b0);
    send(0, 8'h00, 1'b1);
    send(0, 8'h01, 1'b0);
    chk("t2_wrap_result", 32'(last_res[0]), 32'h06);
    send(0, 8'h01, 1'b0);
    send(0, 8'h01, 1'b1);
    idle(4);
    chk("t2_kfins", 32'(kcnt[0] - kc), 32'd2);
    chk("t2_bp_result", 32'(last_res[0]), 32'h07);

    // 01,02,04,FF(last): one n-gram 04, leftover dropped
    kc = kcnt[0]; fc = fcnt[0];
    send(0, 8'h01, 1'b0);
    send(0, 8'h02, 1'b0);
    send(0, 8'h04, 1'b0);
    send(0, 8'hFF, 1'b1);
    idle(4);
    chk("t3_kfins", 32'(kcnt[0] - kc), 32'd1);
    chk("t3_result", 32'(last_res[0]), 32'h04);
    chk("t3_sfins", 32'(fcnt[0] - fc), 32'd1);
    chk("t3_cnt_in_fin", fin_cnt[0], 32'd1);
    chk("t3_cnt_after", ngram_cnt[0], 32'd0);

    // first beat is last with N=3: s_fin, no k_fin, count 0
    kc = kcnt[0]; fc = fcnt[0];
    send(0, 8'h55, 1'b1);
    idle(4);
    chk("t4_kfins", 32'(kcnt[0] - kc), 32'd0);
    chk("t4_sfins", 32'(fcnt[0] - fc), 32'd1);
    chk("t4_cnt_in_fin", fin_cnt[0], 32'd0);

    // N=1: 3C, A5(last)
    kc = kcnt[1]; fc = fcnt[1];
    send(1, 8'h3C, 1'b0);
    send(1, 8'hA5, 1'b1);
    idle(4);
    chk("n1_kfins", 32'(kcnt[1] - kc), 32'd2);
    chk("n1_first", 32'(prev_res[1]), 32'h3C);
    chk("n1_second", 32'(last_res[1]), 32'hA5);
    chk("n1_back_to_back", 32'(k_cyc[1] - prev_k_cyc[1]), 32'd1);
    chk("n1_fin_gap", 32'(f_cyc[1] - k_cyc[1]), 32'd1);
    chk("n1_cnt_in_fin", fin_cnt[1], 32'd2);

    // async reset after 2 of 3 items, then a clean sample
    kc = kcnt[0]; fc = fcnt[0];
    send(0, 8'h01, 1'b0);
    send(0, 8'h01, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("ar_result", 32'(result[0]), 32'h0);
    chk("ar_result_n1", 32'(result[1]), 32'h0);
    chk("ar_kfin", 32'(k_fin), 32'h0);
    chk("ar_sfin", 32'(s_fin), 32'h0);
    chk("ar_ready", 32'(s_ready), 32'h0);
    chk("ar_cnt", ngram_cnt[0], 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #2;
    chk("ar_no_pulses", 32'(kcnt[0] - kc + fcnt[0] - fc), 32'd0);
    send(0, 8'h01, 1'b0);
    send(0, 8'h01, 1'b0);
    send(0, 8'h01, 1'b1);
    idle(4);
    chk("ar_kfins", 32'(kcnt[0] - kc), 32'd1);
    chk("ar_result_fresh", 32'(last_res[0]), 32'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ngram_binder.md
Name: ngram_binder

Overview:
- Upstream feeder of the per-dimension bundling counters.
- Accepts a stream of item hypervector slices, one D-bit slice per beat, and binds every N consecutive items into one n-gram: ngram = rho^(N-1)(x0) ^ ... ^ rho(x(N-2)) ^ x(N-1), where rho is a 1-bit left rotate.
- Bit j of each n-gram drives result_bit of counter lane j, with a one-cycle k_fin pulse.
- At sample end it issues a single s_fin pulse that clears the counters.

Parameters:
- D, 32: slice width; one output bit per downstream counter lane.
- N, 3: n-gram length, legal range 1..255.
- CW, 32: width of the per-sample n-gram counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  item beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  D  item hypervector slice.
- s_last  in  1  beat is the last item of the current sample.
- result  out  D  bound n-gram, bit j goes to lane j's result_bit.
- k_fin  out  1  one-cycle pulse: result holds a completed n-gram.
- s_fin  out  1  one-cycle pulse: sample finished, counters clear.
- ngram_cnt  out  CW  n-grams emitted in the current sample.

Behaviour:
- Reset (asynchronous, active-high):
  - result=0, k_fin=0, s_fin=0, ngram_cnt=0, s_ready=0 while rst is high.
  - Internal acc=0, item index idx=0, state=ACC.
  - s_ready=1 from the first cycle after rst deasserts.
  - Reset mid-sample discards the partial n-gram and emits no pulses.
- Accept: a beat transfers on a rising edge with s_valid && s_ready. s_data is sampled only on that edge.
- FSM states:
  - ACC: s_ready=1.
  - DRAIN: s_ready=0, exactly 1 cycle.
  - FIN: s_ready=0, s_fin=1, exactly 1 cycle.
- ACC transfer with idx<N-1: acc <= rotl1(acc) ^ s_data; idx <= idx+1.
- ACC transfer with idx==N-1:
  - result <= rotl1(acc) ^ s_data; k_fin <= 1 for the next cycle only.
  - acc <= 0; idx <= 0; ngram_cnt <= ngram_cnt+1 (wraps modulo 2^CW).
- N=1: every beat is an n-gram; result = s_data.
- Latency: k_fin/result are visible in the cycle right after the accepting edge. result holds its value until the next n-gram completes.
- s_last transfer:
  - Completes the current n-gram normally if idx==N-1.
  - Otherwise the partial acc is discarded; no k_fin.
  - acc and idx are cleared in both cases; state -> DRAIN.
- DRAIN -> FIN -> ACC unconditionally.
  - s_fin is high in the FIN cycle, always exactly one cycle after any final k_fin, never coincident with it.
  - Downstream sign bits are valid for capture during the FIN cycle.
  - On the edge ending FIN: ngram_cnt <= 0.
- Beats presented during DRAIN/FIN are held by the source: not accepted, no state change.
- k_fin and s_fin are never high in the same cycle.
- A sample with s_last on its first beat and N>1 yields s_fin with ngram_cnt=0 and no k_fin.

Test Plan:
- D=8,N=3: beats 01,01,01(last), s_valid held high -> k_fin one cycle after 3rd accept with result=8'h07, ngram_cnt=1; s_fin exactly 1 cycle later; s_ready=0 for 2 cycles, then 1.
- D=8,N=3: beats 81,00,00 -> result=8'h06 (rotate wrap of MSB into bit 0 checked), one k_fin.
- D=8,N=3: beats 01,02,04,FF(last) -> one k_fin (result=8'h04), leftover FF discarded, no 2nd k_fin, s_fin follows, ngram_cnt=1 during FIN, 0 after.
- Backpressure: s_valid high with new-sample data during DRAIN/FIN -> no acceptance; the beat is accepted on the first ACC cycle and starts a fresh n-gram (acc=0).
- N=1, D=8: beats 3C,A5(last) -> k_fin on 2 consecutive cycles with result=3C then A5; s_fin 1 cycle after the second.
- rst asserted asynchronously after 2 of 3 items -> outputs 0 immediately; after release, beats 01,01,01 give result=8'h07 (no stale acc).
